// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer.
// Covers the sequencer FSM states, the processor opcode field values and the word width.
package seq_pkg;

    localparam int WORD_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        IMM,
        WAIT,
        HALT
    } seq_state_e;

    // Opcode occupies the top three bits of an instruction word (III XXX YYY)
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

endpackage

// File: rtl/program_ram.sv
// Program memory: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module program_ram
    import seq_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Write port: the new word is visible after the clock edge
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port is combinational so DIN follows pc within the same cycle
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_sequencer.sv
// Instruction feeder for the 9-bit bus processor. It issues each program word with a
// one-cycle Run pulse, supplies the mvi immediate in the next cycle, then waits for Done.
// Optional feature macro: SEQ_TIMEOUT_EN adds a Done watchdog that raises Error and halts.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W:0]   Length,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [WORD_W-1:0] LoadData,
    input  logic              Done,
    output logic              Run,
    output logic [WORD_W-1:0] DIN,
    output logic              Busy,
    output logic              Halted,
    output logic [7:0]        InstrCount,
    output logic              Error
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    seq_state_e        state_q, state_d;
    logic [ADDR_W:0]   pc_q, pc_d;
    logic [7:0]        icount_q, icount_d;
    logic [WORD_W-1:0] ram_rdata;
    logic [WORD_W-1:0] fetch_word;
    logic              ram_we;
    logic              accept_start;
    logic              complete;
    logic              waiting;
    logic              timeout_hit;

    // Loads are only accepted while no program is executing
    assign ram_we = LoadEn && ((state_q == IDLE) || (state_q == HALT));

    program_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (Clock),
        .we_i    (ram_we),
        .waddr_i (LoadAddr),
        .wdata_i (LoadData),
        .raddr_i (pc_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    // Addresses past the end of memory read as zero
    assign fetch_word = (pc_q < DEPTH_L) ? ram_rdata : '0;

    assign accept_start = Start && (Length != '0) &&
                          ((state_q == IDLE) || (state_q == HALT));
    assign waiting      = ((state_q == IMM) || (state_q == WAIT)) && !Done;

    // Next-state, program counter and completion counter
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        complete = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                if (accept_start) begin
                    state_d  = ISSUE;
                    pc_d     = '0;
                    icount_d = '0;
                end
            end
            ISSUE: begin
                // Done cannot arrive in the Run cycle, so it is not looked at here
                pc_d    = pc_q + 1'b1;
                state_d = (fetch_word[WORD_W-1 -: 3] == OP_MVI) ? IMM : WAIT;
            end
            IMM: begin
                pc_d = pc_q + 1'b1;
                if (Done) begin
                    complete = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (Done) begin
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion compares against the already-advanced pc so a trailing immediate counts
        if (complete) begin
            if (icount_q != 8'hFF) begin
                icount_d = icount_q + 8'd1;
            end
            state_d = (pc_d >= Length) ? HALT : ISSUE;
        end

        if (timeout_hit) begin
            state_d = HALT;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TIMEOUT_L = TIMEOUT[TMO_W-1:0];

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_inc;

    assign tmo_inc     = tmo_q + 1'b1;
    assign timeout_hit = waiting && (tmo_inc == TIMEOUT_L);

    // Watchdog counts IMM/WAIT cycles since the Run without a Done
    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q == ISSUE) begin
            tmo_d = '0;
        end else if (waiting) begin
            tmo_d = tmo_inc;
        end
        if (accept_start) begin
            err_d = 1'b0;
        end else if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    // Watchdog counter and sticky error flag
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign Error = err_q;
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
    logic unused_waiting;

    assign unused_waiting = waiting;
    assign timeout_hit    = 1'b0;
    assign Error          = 1'b0;
`endif

    // Sequencer state, program counter and instruction count
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
        end
    end

    // Run is a decode of the registered state; DIN carries memory data only while fetching
    assign Run        = (state_q == ISSUE);
    assign DIN        = ((state_q == ISSUE) || (state_q == IMM)) ? fetch_word : '0;
    assign Busy       = (state_q == ISSUE) || (state_q == IMM) || (state_q == WAIT);
    assign Halted     = (state_q == HALT);
    assign InstrCount = icount_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed testbench for program_sequencer with hand-computed expectations.
// Honours SEQ_TIMEOUT_EN to select the watchdog scenario.
module tb_program_sequencer;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic [5:0] Length;
    logic       LoadEn;
    logic [4:0] LoadAddr;
    logic [8:0] LoadData;
    logic       Done;
    logic       Run;
    logic [8:0] DIN;
    logic       Busy;
    logic       Halted;
    logic [7:0] InstrCount;
    logic       Error;

    int n_vec  = 0;
    int n_miss = 0;

    program_sequencer #(
        .DEPTH   (32),
        .ADDR_W  (5),
        .TIMEOUT (16)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Length     (Length),
        .LoadEn     (LoadEn),
        .LoadAddr   (LoadAddr),
        .LoadData   (LoadData),
        .Done       (Done),
        .Run        (Run),
        .DIN        (DIN),
        .Busy       (Busy),
        .Halted     (Halted),
        .InstrCount (InstrCount),
        .Error      (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one edge; inputs change and outputs are checked 1 ns after the edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_word(input logic [4:0] a, input logic [8:0] d);
        LoadEn   = 1'b1;
        LoadAddr = a;
        LoadData = d;
        tick();
        LoadEn   = 1'b0;
    endtask

    // Pulse Start for one edge; returns in the ISSUE cycle when accepted
    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic pulse_done();
        Done = 1'b1;
        tick();
        Done = 1'b0;
    endtask

    initial begin
        Reset    = 1'b0;
        Start    = 1'b0;
        Length   = '0;
        LoadEn   = 1'b0;
        LoadAddr = '0;
        LoadData = '0;
        Done     = 1'b0;

        // Reset values
        repeat (2) @(posedge Clock);
        #1;
        check_eq("rst_run",    Run,        0);
        check_eq("rst_din",    DIN,        0);
        check_eq("rst_busy",   Busy,       0);
        check_eq("rst_halted", Halted,     0);
        check_eq("rst_icount", InstrCount, 0);
        check_eq("rst_error",  Error,      0);
        Reset = 1'b1;
        tick();

        // Length = 0: Start ignored in IDLE
        Length = 6'd0;
        pulse_start();
        check_eq("len0_run",  Run,    0);
        check_eq("len0_busy", Busy,   0);
        tick();
        check_eq("len0_run2", Run,    0);
        check_eq("len0_halt", Halted, 0);

        // Program: mvi R0,#5 ; add R0,R0
        load_word(5'd0, 9'o100);
        load_word(5'd1, 9'o005);
        load_word(5'd2, 9'o200);
        Length = 6'd3;

        pulse_start();
        check_eq("p1_issue_run", Run,  1);
        check_eq("p1_issue_din", DIN,  9'o100);
        check_eq("p1_busy",      Busy, 1);
        tick();
        check_eq("p1_imm_run",   Run,  0);
        check_eq("p1_imm_din",   DIN,  9'o005);
        tick();
        check_eq("p1_wait_din",  DIN,  0);
        pulse_done();
        check_eq("p1_add_run",   Run,  1);
        check_eq("p1_add_din",   DIN,  9'o200);
        tick();
        check_eq("p1_wait2_run", Run,  0);
        pulse_done();
        check_eq("p1_halted",    Halted,     1);
        check_eq("p1_icount",    InstrCount, 2);
        check_eq("p1_busy_off",  Busy,       0);

        // Done in IMM cycle, with a write attempt to address 0 while busy
        pulse_start();
        check_eq("p2_issue_din", DIN, 9'o100);
        tick();
        LoadEn   = 1'b1;
        LoadAddr = 5'd0;
        LoadData = 9'o777;
        pulse_done();
        LoadEn   = 1'b0;
        check_eq("p2_next_run",  Run, 1);
        check_eq("p2_next_din",  DIN, 9'o200);
        tick();
        pulse_done();
        check_eq("p2_halted",    Halted,     1);
        check_eq("p2_icount",    InstrCount, 2);

        // Restart shows the original word; then reset during WAIT of the add
        pulse_start();
        check_eq("p3_word0",     DIN, 9'o100);
        tick();
        pulse_done();
        check_eq("p3_add_run",   Run, 1);
        tick();
        check_eq("p3_icount_pre", InstrCount, 1);
        #2;
        Reset = 1'b0;
        #1;
        check_eq("p3_rst_run",    Run,        0);
        check_eq("p3_rst_busy",   Busy,       0);
        check_eq("p3_rst_icount", InstrCount, 0);
        check_eq("p3_rst_halted", Halted,     0);
        tick();
        Reset = 1'b1;
        tick();
        check_eq("p3_idle_run",   Run, 0);
        pulse_start();
        check_eq("p3_rerun_run",  Run, 1);
        check_eq("p3_rerun_din",  DIN, 9'o100);
        tick();
        pulse_done();
        tick();
        pulse_done();
        check_eq("p3_halted",     Halted, 1);

        // mvi at the last address still fetches its immediate beyond Length
        Length = 6'd1;
        pulse_start();
        check_eq("p4_issue_din", DIN, 9'o100);
        tick();
        check_eq("p4_imm_din",   DIN, 9'o005);
        pulse_done();
        check_eq("p4_halted",    Halted,     1);
        check_eq("p4_icount",    InstrCount, 1);

        // Done withheld
        Length = 6'd3;
        pulse_start();
        check_eq("p5_issue_run", Run, 1);
`ifdef SEQ_TIMEOUT_EN
        repeat (16) tick();
        check_eq("p5_c16_busy",  Busy,   1);
        check_eq("p5_c16_error", Error,  0);
        tick();
        check_eq("p5_tmo_halt",  Halted, 1);
        check_eq("p5_tmo_error", Error,  1);
        pulse_start();
        check_eq("p5_err_clear", Error,  0);
        check_eq("p5_rerun",     Run,    1);
`else
        repeat (40) tick();
        check_eq("p5_stuck_busy", Busy,   1);
        check_eq("p5_no_error",   Error,  0);
        check_eq("p5_no_halt",    Halted, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
